// File: rtl/pixel_stream_pkg.sv
// Shared types and defaults for the pixel frame transmitter and the
// control block on the receiving end of the In_Valid stream.
package pixel_stream_pkg;

    localparam int DEF_DATA_W   = 8;
    localparam int DEF_IMG_W    = 64;
    localparam int DEF_IMG_H    = 64;
    localparam int DEF_ADDR_W   = 12;

    // Cycles spent after the last read so the two pipeline stages empty.
    localparam int DRAIN_CYCLES = 2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } tx_state_e;

    // Counter width that stays at least one bit for a range of 1.
    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/pixel_stream_tx_raster_counter.sv
// Raster-order column/row/linear-address counters for one frame.
// Ports: clk, rst_n (sync, active low), clr_i (restart at pixel 0),
//   en_i (advance one pixel), addr_o (row*IMG_W+col),
//   last_col_o (col at IMG_W-1), last_pixel_o (final pixel of frame).
module raster_counter
    import pixel_stream_pkg::*;
#(
    parameter int IMG_W  = DEF_IMG_W,
    parameter int IMG_H  = DEF_IMG_H,
    parameter int ADDR_W = DEF_ADDR_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr_i,
    input  logic              en_i,
    output logic [ADDR_W-1:0] addr_o,
    output logic              last_col_o,
    output logic              last_pixel_o
);

    localparam int COL_W = cnt_w(IMG_W);
    localparam int ROW_W = cnt_w(IMG_H);

    logic [COL_W-1:0]  col_q, col_d;
    logic [ROW_W-1:0]  row_q, row_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              last_row;

    assign last_col_o   = (col_q == COL_W'(IMG_W - 1));
    assign last_row     = (row_q == ROW_W'(IMG_H - 1));
    assign last_pixel_o = last_col_o && last_row;
    assign addr_o       = addr_q;

    // The linear address runs alongside col/row so no multiplier is needed.
    always_comb begin
        col_d  = col_q;
        row_d  = row_q;
        addr_d = addr_q;
        if (clr_i) begin
            col_d  = '0;
            row_d  = '0;
            addr_d = '0;
        end else if (en_i) begin
            if (last_pixel_o) begin
                col_d  = '0;
                row_d  = '0;
                addr_d = '0;
            end else if (last_col_o) begin
                col_d  = '0;
                row_d  = row_q + ROW_W'(1);
                addr_d = addr_q + ADDR_W'(1);
            end else begin
                col_d  = col_q + COL_W'(1);
                addr_d = addr_q + ADDR_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            col_q  <= '0;
            row_q  <= '0;
            addr_q <= '0;
        end else begin
            col_q  <= col_d;
            row_q  <= row_d;
            addr_q <= addr_d;
        end
    end

endmodule

// File: rtl/pixel_stream_tx.sv
// Frame transmitter: reads one IMG_W x IMG_H frame from a synchronous-read
// pixel memory in raster order and streams it out with SOF/EOL markers.
// Ports: clk, rst_n (sync, active low), start (frame request in IDLE),
//   hold (stall new reads), mem_rd_en/mem_addr/mem_rd_data (memory side,
//   data one cycle after the strobe), In_Valid/In_Data/In_Sof/In_Eol
//   (pixel stream), busy (frame in progress), done (one-cycle end pulse).
module pixel_stream_tx
    import pixel_stream_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int IMG_W  = DEF_IMG_W,
    parameter int IMG_H  = DEF_IMG_H,
    parameter int ADDR_W = DEF_ADDR_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              hold,
    output logic              mem_rd_en,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_rd_data,
    output logic              In_Valid,
    output logic [DATA_W-1:0] In_Data,
    output logic              In_Sof,
    output logic              In_Eol,
    output logic              busy,
    output logic              done
);

    localparam int DRAIN_W = cnt_w(DRAIN_CYCLES);

    tx_state_e          state_q, state_d;
    logic [DRAIN_W-1:0] drain_q, drain_d;

    logic               rd_go;
    logic               cnt_clr;
    logic               last_col;
    logic               last_pixel;
    logic [ADDR_W-1:0]  addr;

    // Stage 1: flags travelling alongside the memory access.
    logic               s1_vld_q, s1_sof_q, s1_eol_q;

    // Stage 2: registered stream outputs.
    logic               out_vld_q, out_sof_q, out_eol_q;
    logic [DATA_W-1:0]  out_data_q;

    assign cnt_clr = (state_q == ST_IDLE) && start;

    raster_counter #(
        .IMG_W  (IMG_W),
        .IMG_H  (IMG_H),
        .ADDR_W (ADDR_W)
    ) u_cnt (
        .clk          (clk),
        .rst_n        (rst_n),
        .clr_i        (cnt_clr),
        .en_i         (rd_go),
        .addr_o       (addr),
        .last_col_o   (last_col),
        .last_pixel_o (last_pixel)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            drain_q <= '0;
        end else begin
            state_q <= state_d;
            drain_q <= drain_d;
        end
    end

    always_comb begin
        state_d = state_q;
        drain_d = '0;
        unique case (state_q)
            ST_IDLE: begin
                if (start) state_d = ST_READ;
            end
            ST_READ: begin
                if (rd_go && last_pixel) state_d = ST_DRAIN;
            end
            ST_DRAIN: begin
                drain_d = drain_q + DRAIN_W'(1);
                if (drain_q == DRAIN_W'(DRAIN_CYCLES - 1)) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                // A start seen here is dropped; it must come again in IDLE.
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // hold gates the read strobe combinationally, so it acts the same cycle.
    always_comb begin
        rd_go = 1'b0;
        busy  = 1'b0;
        done  = 1'b0;
        unique case (state_q)
            ST_READ: begin
                rd_go = !hold;
                busy  = 1'b1;
            end
            ST_DRAIN: busy = 1'b1;
            ST_DONE:  done = 1'b1;
            default: ;
        endcase
    end

    assign mem_rd_en = rd_go;
    assign mem_addr  = addr;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_vld_q   <= 1'b0;
            s1_sof_q   <= 1'b0;
            s1_eol_q   <= 1'b0;
            out_vld_q  <= 1'b0;
            out_sof_q  <= 1'b0;
            out_eol_q  <= 1'b0;
            out_data_q <= '0;
        end else begin
            s1_vld_q   <= rd_go;
            s1_sof_q   <= rd_go && (addr == '0);
            s1_eol_q   <= rd_go && last_col;
            out_vld_q  <= s1_vld_q;
            out_sof_q  <= s1_sof_q;
            out_eol_q  <= s1_eol_q;
            out_data_q <= s1_vld_q ? mem_rd_data : '0;
        end
    end

    assign In_Valid = out_vld_q;
    assign In_Data  = out_data_q;
    assign In_Sof   = out_sof_q;
    assign In_Eol   = out_eol_q;

endmodule

// File: tb/tb_pixel_stream_tx.sv
// Directed, scoreboard-based bench for pixel_stream_tx on a 4x3 frame.
module tb_pixel_stream_tx;

    localparam int DW = 8;
    localparam int W  = 4;
    localparam int H  = 3;
    localparam int AW = 4;
    localparam int NPIX = W * H;

    typedef struct {
        logic [DW-1:0] d;
        logic          sof;
        logic          eol;
    } exp_t;

    logic          clk;
    logic          rst_n;
    logic          start;
    logic          hold;
    logic          mem_rd_en;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_rd_data;
    logic          In_Valid;
    logic [DW-1:0] In_Data;
    logic          In_Sof;
    logic          In_Eol;
    logic          busy;
    logic          done;

    pixel_stream_tx #(
        .DATA_W (DW),
        .IMG_W  (W),
        .IMG_H  (H),
        .ADDR_W (AW)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .hold        (hold),
        .mem_rd_en   (mem_rd_en),
        .mem_addr    (mem_addr),
        .mem_rd_data (mem_rd_data),
        .In_Valid    (In_Valid),
        .In_Data     (In_Data),
        .In_Sof      (In_Sof),
        .In_Eol      (In_Eol),
        .busy        (busy),
        .done        (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [DW-1:0] mem [1 << AW];
    initial begin
        for (int i = 0; i < (1 << AW); i++) mem[i] = DW'(i);
        mem_rd_data = '0;
    end
    always @(posedge clk) begin
        if (mem_rd_en) mem_rd_data <= mem[mem_addr];
    end

    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    exp_t sb[$];

    bit   mon_en = 0;
    bit   vmask [4096];
    int   first_cyc = -1;
    int   last_cyc = -1;
    int   fvcnt = 0;
    int   vtotal = 0;
    int   done_cnt = 0;

    always @(posedge clk) cyc++;

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Stream monitor: pops the scoreboard on every valid pixel.
    always @(negedge clk) begin
        if (mon_en) begin
            if (done === 1'b1) done_cnt++;
            if (In_Valid === 1'b1) begin
                vmask[cyc] = 1'b1;
                vtotal++;
                if (In_Sof === 1'b1) begin
                    first_cyc = cyc;
                    fvcnt = 0;
                end
                fvcnt++;
                last_cyc = cyc;
                if (sb.size() == 0) begin
                    check("sb_empty", 1, 0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check("px_data", int'(In_Data), int'(e.d));
                    check("px_sof", int'(In_Sof), int'(e.sof));
                    check("px_eol", int'(In_Eol), int'(e.eol));
                end
            end else if (In_Sof !== 1'b0 || In_Eol !== 1'b0) begin
                check("marker_idle", int'({In_Sof, In_Eol}), 0);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_frame();
        exp_t e;
        for (int i = 0; i < NPIX; i++) begin
            e.d   = DW'(i);
            e.sof = (i == 0);
            e.eol = ((i % W) == W - 1);
            sb.push_back(e);
        end
    endtask

    task automatic wait_done(input string tag, input int budget);
        bit seen;
        seen = 0;
        for (int i = 0; i < budget && !seen; i++) begin
            tick();
            if (done === 1'b1) seen = 1;
        end
        check({tag, "_done_seen"}, int'(seen), 1);
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_outs"},
              int'({mem_rd_en, In_Valid, In_Data, In_Sof, In_Eol, busy, done}),
              0);
        check({tag, "_addr"}, int'(mem_addr), 0);
    endtask

    // Unthrottled frame: start in the current cycle, return at the done cycle.
    task automatic plain_frame(input string tag, output int st);
        int bad;
        push_frame();
        st = cyc;
        start = 1'b1;
        tick();
        start = 1'b0;
        check({tag, "_rd_first"}, int'(mem_rd_en), 1);
        check({tag, "_busy"}, int'(busy), 1);
        wait_done(tag, 40);
        check({tag, "_done_cyc"}, cyc, st + 3 + NPIX);
        check({tag, "_first"}, first_cyc, st + 3);
        check({tag, "_last"}, last_cyc, st + 2 + NPIX);
        check({tag, "_count"}, fvcnt, NPIX);
        check({tag, "_busy_low"}, int'(busy), 0);
        bad = 0;
        for (int k = 0; k <= NPIX; k++) begin
            if (vmask[st + 3 + k] != (k < NPIX)) bad++;
        end
        check({tag, "_vpattern"}, bad, 0);
        check({tag, "_sb_left"}, sb.size(), 0);
    endtask

    initial begin
        int st;
        int st2;
        int prev_last;
        int bad;
        int v0;
        int d0;
        bit any;

        rst_n = 1'b0;
        start = 1'b0;
        hold  = 1'b0;
        tick();
        tick();
        check_zero("reset");
        rst_n = 1'b1;
        mon_en = 1;
        v0 = vtotal;
        any = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (In_Valid !== 1'b0 || busy !== 1'b0 || mem_rd_en !== 1'b0) any = 1;
        end
        check("idle_quiet", int'(any), 0);
        check("idle_vcnt", vtotal - v0, 0);

        plain_frame("f1", st);
        tick();
        check("f1_done_pulse", int'(done), 0);

        // Throttle on READ cycles 2, 3 and 7.
        tick();
        push_frame();
        st = cyc;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int r = 0; r < NPIX + 3; r++) begin
            hold = (r == 2 || r == 3 || r == 7);
            #1;
            check("thr_rd_gate", int'(mem_rd_en), int'(!hold));
            tick();
        end
        hold = 1'b0;
        wait_done("thr", 40);
        check("thr_done_cyc", cyc, st + 6 + NPIX);
        check("thr_count", fvcnt, NPIX);
        bad = 0;
        for (int k = 0; k <= NPIX + 3; k++) begin
            if (vmask[st + 3 + k] != (k < NPIX + 3 && k != 2 && k != 3 && k != 7))
                bad++;
        end
        check("thr_vpattern", bad, 0);
        check("thr_sb_left", sb.size(), 0);

        // Starts during READ and in the DONE cycle are ignored.
        tick();
        push_frame();
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (4) tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_done("ign", 40);
        check("ign_count", fvcnt, NPIX);
        start = 1'b1;
        tick();
        start = 1'b0;
        v0 = vtotal;
        any = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (busy !== 1'b0 || mem_rd_en !== 1'b0) any = 1;
        end
        check("ign_idle", int'(any), 0);
        check("ign_no_frame", vtotal - v0, 0);

        // Reset in the middle of a frame.
        push_frame();
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 30 && fvcnt < 6; i++) tick();
        check("rst_reached", int'(fvcnt >= 6), 1);
        rst_n = 1'b0;
        tick();
        check_zero("rst_mid");
        rst_n = 1'b1;
        sb.delete();
        d0 = done_cnt;
        v0 = vtotal;
        repeat (10) tick();
        check("rst_no_done", done_cnt - d0, 0);
        check("rst_no_valid", vtotal - v0, 0);
        plain_frame("rst_f", st);

        // Back-to-back frames.
        tick();
        plain_frame("b2b_a", st);
        prev_last = last_cyc;
        tick();
        plain_frame("b2b_b", st2);
        check("b2b_gap", first_cyc - prev_last - 1, 4);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/pixel_stream_tx.md
# pixel_stream_tx

Frame transmitter feeding the processing core's valid-qualified input stream. On `start`, reads one IMG_W×IMG_H frame from a synchronous-read pixel memory in raster order. Drives `In_Valid`/`In_Data` with start-of-frame and end-of-line markers. Honours a `hold` throttle and reports completion, acting as the producer end of the `In_Valid` interface that the core's control logic consumes.

## Interface
- DATA_W, 8, pixel width
- IMG_W, 64, pixels per line (≥2)
- IMG_H, 64, lines per frame (≥1)
- ADDR_W, 12, memory address width; IMG_W*IMG_H ≤ 2^ADDR_W
- clk  in  1  sole clock, rising edge
- rst_n  in  1  synchronous, active-low reset
- start  in  1  frame request, sampled only in IDLE
- hold  in  1  throttle; while 1 no new memory reads are issued
- mem_rd_en  out  1  memory read strobe
- mem_addr  out  ADDR_W  read address, linear raster index
- mem_rd_data  in  DATA_W  read data, valid the cycle after `mem_rd_en`
- In_Valid  out  1  pixel strobe to core
- In_Data  out  DATA_W  pixel, qualified by `In_Valid`
- In_Sof  out  1  with first pixel of frame
- In_Eol  out  1  with last pixel of each line
- busy  out  1  frame in progress
- done  out  1  one-cycle pulse after last pixel

## Operation
- Reset (rst_n=0 at an edge): all outputs 0, FSM → IDLE, counters 0, in-flight reads discarded. Applies mid-frame with no partial completion; `done` is not pulsed.
- FSM states:
  - IDLE: start=1 → READ; busy=1 from next cycle.
  - READ: each cycle with hold=0 issues mem_rd_en=1 at current addr, then advances col, and row when col wraps IMG_W-1→0. Issuing index IMG_W*IMG_H-1 → DRAIN.
  - DRAIN: waits for pipeline empty (2 cycles) → DONE.
  - DONE: done=1 for one cycle, busy=0 → IDLE.
- hold=1 in READ: mem_rd_en=0, counters frozen. Reads already issued still emerge on In_Valid. hold has no effect in IDLE, DRAIN and DONE.
- Pipeline stage 1 registers rd_en, sof, eol flags alongside the memory access. Stage 2 registers In_Valid, In_Data←mem_rd_data, In_Sof, In_Eol.
- Marker rules:
  - sof=1 for addr 0.
  - eol=1 when col=IMG_W-1.
  - Both are 0 whenever In_Valid=0.
- mem_addr = row*IMG_W+col, computed by an incrementing register, no multiplier. Holds last value when rd_en=0. 0 after reset.
- start while busy: ignored. start asserted in the DONE cycle: ignored; must be re-presented in IDLE.
- Exactly IMG_W*IMG_H In_Valid pulses per frame, in address order, regardless of hold pattern.

## Timing
- start sampled at edge E0. First mem_rd_en in cycle after E0. First In_Valid two cycles later. Latency start→first pixel = 3 cycles.
- Without hold: In_Valid continuous for IMG_W*IMG_H cycles.
- done asserted the cycle after final In_Valid. busy falls with done.
- Back-to-back frames: start in the cycle after done → new frame, giving a 4-cycle minimum inter-frame gap.
- hold→read effect same cycle (combinational gate on rd_en). hold effect on In_Valid lags 2 cycles.

## Structure
- Package pixel_stream_pkg:
  - FSM state enum (IDLE, READ, DRAIN, DONE).
  - Default IMG_W/IMG_H/DATA_W constants.
  - Shared with the receiving control block.
- Sub-module raster_counter:
  - col/row/addr counters with enable.
  - Outputs: last_col, last_pixel.
- Top holds the FSM and the 2-stage flag/data pipeline.

## Test plan
- Reset then idle: rst_n=0 two cycles, start=0 → all outputs 0, mem_addr=0, no In_Valid for 20 cycles.
- Full frame, IMG_W=4, IMG_H=3, mem[i]=i, hold=0 → In_Data 0..11 on 12 consecutive cycles starting 3 cycles after start. In_Sof only on 0. In_Eol on 3, 7, 11. done one cycle after 11.
- Throttle: hold=1 on cycles 2,3,7 of READ → same 12 values in order, In_Valid gaps match hold pattern delayed 2 cycles, frame ends 3 cycles later than unthrottled.
- Ignored start: start pulses during READ and in the DONE cycle → exactly one frame, busy low after done.
- Reset mid-frame after pixel 5 → outputs 0 next cycle, no done. New start → frame restarts at addr 0 with In_Sof.
- Back-to-back: start the cycle after done → second frame identical, first In_Valid 3 cycles after start.
